s_box_enc_serial: RTL and testbench

Nibble-serial BORON forward S-box layer for the encryption datapath. It takes a 64-bit round state, substitutes all 16 nibbles through the BORON encryption S-box over 16/LANES cycles, and returns the result with a valid/ready handshake. It is the encryption-direction counterpart of s_box_dec. It sits between the round-key XOR and the permutation layer, where a folded, low-area round needs fewer S-box instances than nibbles.

---
 rtl/s_box_enc_serial_if.sv | 35 +++
 rtl/s_box_enc_serial.sv | 137 +++++++++++++
 tb/tb_s_box_enc_serial.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/s_box_enc_serial_if.sv
`default_nettype none
// ============================================================================
// Module   : s_box_enc_serial_if
// Brief    : Valid/ready handshake bundle for the serial forward S-box layer.
// Revision : 1.0 - initial release
// ============================================================================

interface s_box_enc_serial_if;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;

    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data
    );
endinterface

`default_nettype wire

// File: rtl/s_box_enc_serial.sv
`default_nettype none
// ============================================================================
// Module   : s_box_enc_serial
// Brief    : Nibble-serial BORON forward S-box layer, LANES nibbles per cycle.
// Revision : 1.0 - initial release
// ============================================================================

module s_box_enc_serial #(
    parameter int LANES = 4
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    s_box_enc_serial_if.slave  bus
);

    localparam int N  = 16 / LANES;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]           r_state;
    logic [1:0]           w_state_nxt;
    logic [63:0]          r_work;
    logic [63:0]          w_work_nxt;
    logic [63:0]          w_sub;
    logic [CW-1:0]        w_base;
    logic                 w_last;
    logic [3:0]           w_first;
    logic [LANES*4-1:0]   w_sbox_out;
    logic [5:0]           w_lo [LANES];

    function automatic logic [3:0] f_sbox(input logic [3:0] x);
        case (x)
            4'h0: f_sbox = 4'hE;
            4'h1: f_sbox = 4'h4;
            4'h2: f_sbox = 4'hB;
            4'h3: f_sbox = 4'h1;
            4'h4: f_sbox = 4'h7;
            4'h5: f_sbox = 4'h9;
            4'h6: f_sbox = 4'hC;
            4'h7: f_sbox = 4'hA;
            4'h8: f_sbox = 4'hD;
            4'h9: f_sbox = 4'h2;
            4'hA: f_sbox = 4'h0;
            4'hB: f_sbox = 4'hF;
            4'hC: f_sbox = 4'h8;
            4'hD: f_sbox = 4'h5;
            4'hE: f_sbox = 4'h3;
            default: f_sbox = 4'h6;
        endcase
    endfunction

    // With a single chunk the whole state is substituted in one RUN cycle.
    generate
        if (N > 1) begin : g_cnt
            logic [CW-1:0] r_cnt;

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    r_cnt <= '0;
                end else if (r_state == S_RUN) begin
                    r_cnt <= r_cnt + CW'(1);
                end else begin
                    r_cnt <= '0;
                end
            end

            assign w_base = r_cnt;
            assign w_last = (r_cnt == CW'(N - 1));
        end else begin : g_nocnt
            assign w_base = '0;
            assign w_last = 1'b1;
        end
    endgenerate

    assign w_first = 4'(w_base) * 4'(LANES);

    generate
        for (genvar l = 0; l < LANES; l++) begin : g_lane
            assign w_lo[l]                = {w_first + 4'(l), 2'b00};
            assign w_sbox_out[l*4 +: 4]   = f_sbox(r_work[w_lo[l] +: 4]);
        end
    endgenerate

    always_comb begin
        w_sub = r_work;
        for (int l = 0; l < LANES; l++) begin
            w_sub[w_lo[l] +: 4] = w_sbox_out[l*4 +: 4];
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_work_nxt  = r_work;
        case (r_state)
            S_IDLE: begin
                if (bus.in_valid) begin
                    w_state_nxt = S_RUN;
                    w_work_nxt  = bus.in_data;
                end
            end
            S_RUN: begin
                w_work_nxt = w_sub;
                if (w_last) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_work  <= 64'h0;
        end else begin
            r_state <= w_state_nxt;
            r_work  <= w_work_nxt;
        end
    end

    assign bus.in_ready  = rst_n && (r_state == S_IDLE);
    assign bus.out_valid = (r_state == S_DONE);
    assign bus.out_data  = r_work;

endmodule

`default_nettype wire

// File: tb/tb_s_box_enc_serial.sv
`default_nettype none
// ============================================================================
// Module   : tb_s_box_enc_serial
// Brief    : Self-checking bench for s_box_enc_serial against a table model.
// Revision : 1.0 - initial release
// ============================================================================

module tb_s_box_enc_serial;

    localparam int          N     = 4;
    localparam logic [63:0] C_TAB = 64'hE4B179CAD20F8536;

    logic clk = 1'b0;
    logic rst_n;
    logic rst_n_aux;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc   = 0;
    int   n_acc = 0;
    int   last_acc = 0;
    int   aux_done = 0;

    logic [63:0] exp_q [$];
    logic [63:0] src_q [$];
    int          acc_q [$];

    always #5 clk = ~clk;

    s_box_enc_serial_if bus();

    s_box_enc_serial #(.LANES(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    function automatic logic [3:0] sbox4(input logic [3:0] x);
        return C_TAB[60 - 4*int'(x) +: 4];
    endfunction

    function automatic logic [3:0] inv4(input logic [3:0] y);
        logic [3:0] r = 4'h0;
        for (int x = 0; x < 16; x++) if (sbox4(4'(x)) == y) r = 4'(x);
        return r;
    endfunction

    function automatic logic [63:0] sbox64(input logic [63:0] d);
        logic [63:0] r;
        for (int i = 0; i < 16; i++) r[4*i +: 4] = sbox4(d[4*i +: 4]);
        return r;
    endfunction

    function automatic logic [63:0] inv64(input logic [63:0] d);
        logic [63:0] r;
        for (int i = 0; i < 16; i++) r[4*i +: 4] = inv4(d[4*i +: 4]);
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: every accepted state becomes one pending result.
    initial forever begin
        @(posedge clk);
        if (!rst_n) begin
            exp_q.delete(); src_q.delete(); acc_q.delete();
        end else begin
            if (bus.out_valid && bus.out_ready && exp_q.size() > 0) begin
                void'(exp_q.pop_front()); void'(src_q.pop_front()); void'(acc_q.pop_front());
            end
            if (bus.in_valid && bus.in_ready) begin
                exp_q.push_back(sbox64(bus.in_data));
                src_q.push_back(bus.in_data);
                acc_q.push_back(cyc);
                n_acc++;
                last_acc = cyc;
            end
        end
        cyc++;
    end

    // Compare process, sampled on the falling edge.
    initial forever begin
        logic exp_valid;
        @(negedge clk);
        exp_valid = (exp_q.size() > 0) && (cyc - acc_q[0] >= N + 1);
        check("in_ready", {63'h0, bus.in_ready}, {63'h0, (rst_n === 1'b1) && exp_q.size() == 0});
        check("out_valid", {63'h0, bus.out_valid}, {63'h0, exp_valid});
        if (bus.out_valid && exp_q.size() > 0) begin
            check("out_data", bus.out_data, exp_q[0]);
            check("roundtrip", inv64(bus.out_data), src_q[0]);
        end
    end

    task automatic send(input logic [63:0] d);
        int t = 0;
        while (!bus.in_ready && t < 50) begin @(posedge clk); #1; t++; end
        if (t >= 50) check("send_timeout", 64'd1, 64'd0);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.in_data  = {$urandom, $urandom};
    endtask

    task automatic wait_valid();
        int t = 0;
        while (!bus.out_valid && t < 50) begin @(posedge clk); #1; t++; end
        if (t >= 50) check("valid_timeout", 64'd1, 64'd0);
    endtask

    task automatic drain(input int hold);
        wait_valid();
        repeat (hold) begin @(posedge clk); #1; end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
    endtask

    initial begin
        logic [63:0] held;
        int t;
        int prev;
        int base;
        rst_n = 1'b0; rst_n_aux = 1'b0;
        bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;

        check("pin_count", sbox64(64'h0123456789ABCDEF), 64'hE4B179CAD20F8536);
        check("pin_zero",  sbox64(64'h0), 64'hEEEEEEEEEEEEEEEE);
        check("pin_ones",  sbox64(64'hFFFFFFFFFFFFFFFF), 64'h6666666666666666);
        check("pin_desc",  sbox64(64'hFEDCBA9876543210), 64'h6358F02DAC971B4E);
        check("pin_inv",   inv64(64'hE4B179CAD20F8536), 64'h0123456789ABCDEF);

        repeat (2) @(posedge clk); #1;
        check("rst_in_ready", {63'h0, bus.in_ready}, 64'd0);
        check("rst_out_valid", {63'h0, bus.out_valid}, 64'd0);
        check("rst_work", bus.out_data, 64'h0);
        rst_n = 1'b1; rst_n_aux = 1'b1;
        #1;
        check("rel_in_ready", {63'h0, bus.in_ready}, 64'd1);

        // Directed latency and result for the first block.
        send(64'h0123456789ABCDEF);
        repeat (N - 1) @(posedge clk); #1;
        check("lat_before", {63'h0, bus.out_valid}, 64'd0);
        @(posedge clk); #1;
        check("lat_at", {63'h0, bus.out_valid}, 64'd1);
        check("first_data", bus.out_data, 64'hE4B179CAD20F8536);
        drain(0);

        send(64'h0);                 drain(0);
        send(64'hFFFFFFFFFFFFFFFF);  drain(1);
        send(64'hFEDCBA9876543210);  drain(0);

        // Long backpressure with noise on the input side.
        send({$urandom, $urandom});
        wait_valid();
        held = bus.out_data;
        repeat (10) begin
            bus.in_valid = 1'($urandom);
            bus.in_data  = {$urandom, $urandom};
            @(posedge clk); #1;
            check("hold_data", bus.out_data, held);
            check("hold_in_ready", {63'h0, bus.in_ready}, 64'd0);
        end
        // out_ready and in_valid together: only the output side completes.
        bus.in_valid = 1'b1; bus.in_data = 64'h0123456789ABCDEF; bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        check("after_release_idle", {63'h0, bus.in_ready}, 64'd1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        check("late_accept", {63'h0, bus.in_ready}, 64'd0);
        drain(0);

        // Reset after two of four chunks.
        send(64'hFEDCBA9876543210);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("midrst_work", bus.out_data, 64'h0);
        check("midrst_valid", {63'h0, bus.out_valid}, 64'd0);
        check("midrst_in_ready", {63'h0, bus.in_ready}, 64'd0);
        rst_n = 1'b1;
        #1;
        check("midrst_rel", {63'h0, bus.in_ready}, 64'd1);
        repeat (8) @(posedge clk); #1;
        send(64'h0123456789ABCDEF); drain(0);

        for (int i = 0; i < 1000; i++) begin
            send({$urandom, $urandom});
            drain(int'($urandom_range(0, 3)));
        end

        // Back-to-back with out_ready tied high.
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_data   = {$urandom, $urandom};
        base = n_acc;
        prev = 0;
        for (int b = 0; b < 20; b++) begin
            t = 0;
            while (n_acc == base + b && t < 50) begin @(posedge clk); #1; t++; end
            if (t >= 50) check("b2b_timeout", 64'd1, 64'd0);
            bus.in_data = {$urandom, $urandom};
            if (b > 0) check("b2b_gap", 64'(last_acc - prev), 64'(N + 2));
            prev = last_acc;
        end
        bus.in_valid = 1'b0;
        repeat (10) @(posedge clk); #1;
        bus.out_ready = 1'b0;

        t = 0;
        while (aux_done < 4 && t < 1000) begin @(posedge clk); #1; t++; end
        if (t >= 1000) check("aux_timeout", 64'd1, 64'd0);
        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // The remaining lane counts run the directed vectors in parallel.
    for (genvar g = 0; g < 4; g++) begin : g_aux
        localparam int L  = (g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 8 : 16;
        localparam int NL = 16 / L;

        s_box_enc_serial_if abus();

        s_box_enc_serial #(.LANES(L)) u_dut (
            .clk   (clk),
            .rst_n (rst_n_aux),
            .bus   (abus.slave)
        );

        initial begin
            logic [63:0] vin [4];
            logic [63:0] vout [4];
            int t;
            vin[0] = 64'h0123456789ABCDEF; vout[0] = 64'hE4B179CAD20F8536;
            vin[1] = 64'h0;                vout[1] = 64'hEEEEEEEEEEEEEEEE;
            vin[2] = 64'hFFFFFFFFFFFFFFFF; vout[2] = 64'h6666666666666666;
            vin[3] = 64'hFEDCBA9876543210; vout[3] = 64'h6358F02DAC971B4E;
            abus.in_valid = 1'b0; abus.in_data = '0; abus.out_ready = 1'b0;
            t = 0;
            while (rst_n_aux !== 1'b1 && t < 20) begin @(posedge clk); #1; t++; end
            #1;
            for (int v = 0; v < 4; v++) begin
                @(posedge clk); #1;
                check($sformatf("aux%0d_ready", L), {63'h0, abus.in_ready}, 64'd1);
                abus.in_valid = 1'b1;
                abus.in_data  = vin[v];
                @(posedge clk); #1;
                abus.in_valid = 1'b0;
                abus.in_data  = {$urandom, $urandom};
                t = 0;
                while (!abus.out_valid && t < 40) begin @(posedge clk); #1; t++; end
                check($sformatf("aux%0d_latency", L), 64'(t), 64'(NL));
                check($sformatf("aux%0d_data", L), abus.out_data, vout[v]);
                abus.out_ready = 1'b1;
                @(posedge clk); #1;
                abus.out_ready = 1'b0;
            end
            aux_done++;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
